ps2_voice_allocator: RTL and testbench

Polyphonic note scheduler between the PS/2 controller and the per-voice square-wave tone generators. It consumes the received scancode byte stream and decodes make, break (`F0`) and extended (`E0`) prefixes. It assigns held note keys to a fixed pool of voices and drives each voice's gate and half-period count. The audio mixer sums the gated voices.

---
 rtl/ps2_voice_allocator.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_voice_allocator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_voice_allocator.sv
// ps2_voice_allocator: PS/2 scancode decoder and polyphonic voice pool.
// Optional macro VOICE_STEAL_EN: steal oldest voice when pool is full.
module ps2_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int HP_W       = 20
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic [7:0]                 received_data,
  input  logic                       received_data_en,
  output logic [NUM_VOICES-1:0]      voice_gate,
  output logic [3*NUM_VOICES-1:0]    voice_note,
  output logic [HP_W*NUM_VOICES-1:0] voice_half_period,
  output logic [2:0]                 octave,
  output logic                       pool_full
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [2:0] RMAX = 3'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t                state_q, state_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [2:0]            note_q [NUM_VOICES];
  logic [2:0]            note_d [NUM_VOICES];
  logic [HP_W-1:0]       hp_q   [NUM_VOICES];
  logic [HP_W-1:0]       hp_d   [NUM_VOICES];
  logic [2:0]            rank_q [NUM_VOICES];
  logic [2:0]            rank_d [NUM_VOICES];
  logic signed [2:0]     oct_q, oct_d;
  logic                  full_q, full_d;

  logic            is_note;
  logic [2:0]      note_idx;
  logic [23:0]     base_w;
  logic [23:0]     shifted;
  logic [2:0]      oct_mag;
  logic [HP_W-1:0] hp_new;

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          do_alloc;
  logic [IW-1:0] alloc_idx;
  logic          do_rel;
  logic          rel_all;
`ifdef VOICE_STEAL_EN
  logic [IW-1:0] old_idx;
  logic [2:0]    old_rank;
`endif

  // Map scancode to note index and base half-period
  always_comb begin
    is_note  = 1'b1;
    note_idx = 3'd0;
    case (received_data)
      8'h16:   note_idx = 3'd0;
      8'h1E:   note_idx = 3'd1;
      8'h26:   note_idx = 3'd2;
      8'h25:   note_idx = 3'd3;
      8'h2E:   note_idx = 3'd4;
      8'h36:   note_idx = 3'd5;
      8'h3D:   note_idx = 3'd6;
      default: is_note  = 1'b0;
    endcase
    case (note_idx)
      3'd0:    base_w = 24'd56818;
      3'd1:    base_w = 24'd50607;
      3'd2:    base_w = 24'd47801;
      3'd3:    base_w = 24'd42589;
      3'd4:    base_w = 24'd37936;
      3'd5:    base_w = 24'd35817;
      default: base_w = 24'd31888;
    endcase
    oct_mag = oct_q[2] ? 3'(-oct_q) : 3'(oct_q);
    shifted = oct_q[2] ? (base_w << oct_mag) : (base_w >> oct_mag);
    hp_new  = HP_W'(shifted);
  end

  // Search the pool: note already held, lowest free voice, oldest voice
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_q[i] && note_q[i] == note_idx) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
`ifdef VOICE_STEAL_EN
    old_idx  = '0;
    old_rank = 3'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate_q[i] && rank_q[i] > old_rank) begin
        old_rank = rank_q[i];
        old_idx  = IW'(i);
      end
    end
`endif
  end

  // Decoder FSM next state and event generation
  always_comb begin
    state_d   = state_q;
    oct_d     = oct_q;
    do_alloc  = 1'b0;
    alloc_idx = free_idx;
    do_rel    = 1'b0;
    rel_all   = 1'b0;
    if (received_data_en) begin
      unique case (state_q)
        IDLE: begin
          if (received_data == 8'hF0) begin
            state_d = BRK;
          end else if (received_data == 8'hE0) begin
            state_d = EXT;
          end else if (is_note) begin
            if (!hit) begin
              if (free_found) begin
                do_alloc = 1'b1;
              end else begin
`ifdef VOICE_STEAL_EN
                do_alloc  = 1'b1;
                alloc_idx = old_idx;
`endif
              end
            end
          end else if (received_data == 8'h76) begin
            rel_all = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          do_rel  = is_note && hit;
        end
        EXT: begin
          if (received_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            if (received_data == 8'h75 && oct_q != 3'sd3)
              oct_d = oct_q + 3'sd1;
            else if (received_data == 8'h72 && oct_q != -3'sd3)
              oct_d = oct_q - 3'sd1;
          end
        end
        EXT_BRK: state_d = IDLE;
      endcase
    end
  end

  // Voice pool update: allocate, release, release-all, re-rank
  always_comb begin
    gate_d = gate_q;
    for (int j = 0; j < NUM_VOICES; j++) begin
      note_d[j] = note_q[j];
      hp_d[j]   = hp_q[j];
      rank_d[j] = rank_q[j];
    end
    if (rel_all) begin
      gate_d = '0;
      for (int j = 0; j < NUM_VOICES; j++) rank_d[j] = 3'd0;
    end else if (do_alloc) begin
      for (int j = 0; j < NUM_VOICES; j++) begin
        if (IW'(j) == alloc_idx) begin
          gate_d[j] = 1'b1;
          note_d[j] = note_idx;
          hp_d[j]   = hp_new;
          rank_d[j] = 3'd0;
        end else if (gate_q[j] && rank_q[j] != RMAX) begin
          rank_d[j] = rank_q[j] + 3'd1;
        end
      end
    end else if (do_rel) begin
      for (int j = 0; j < NUM_VOICES; j++) begin
        if (IW'(j) == hit_idx) begin
          gate_d[j] = 1'b0;
          rank_d[j] = 3'd0;
        end else if (gate_q[j] && rank_q[j] > rank_q[hit_idx]) begin
          rank_d[j] = rank_q[j] - 3'd1;
        end
      end
    end
    full_d = &gate_d;
  end

  // State registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gate_q  <= '0;
      oct_q   <= 3'sd0;
      full_q  <= 1'b0;
      for (int j = 0; j < NUM_VOICES; j++) begin
        note_q[j] <= 3'd0;
        hp_q[j]   <= '0;
        rank_q[j] <= 3'd0;
      end
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      oct_q   <= oct_d;
      full_q  <= full_d;
      for (int j = 0; j < NUM_VOICES; j++) begin
        note_q[j] <= note_d[j];
        hp_q[j]   <= hp_d[j];
        rank_q[j] <= rank_d[j];
      end
    end
  end

  // Flatten per-voice registers onto output buses
  always_comb begin
    voice_note        = '0;
    voice_half_period = '0;
    for (int j = 0; j < NUM_VOICES; j++) begin
      voice_note[3*j +: 3]           = note_q[j];
      voice_half_period[HP_W*j +: HP_W] = hp_q[j];
    end
  end

  assign voice_gate = gate_q;
  assign octave     = oct_q;
  assign pool_full  = full_q;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// tb_ps2_voice_allocator: directed checks of decode, allocation, octave.
// Expectations follow VOICE_STEAL_EN when it is defined.
module tb_ps2_voice_allocator;

  localparam int NV = 4;
  localparam int HW = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rd;
  logic             rd_en;
  logic [NV-1:0]    gate;
  logic [3*NV-1:0]  vnote;
  logic [HW*NV-1:0] vhp;
  logic [2:0]       oct;
  logic             full;

  int nvec = 0;
  int nerr = 0;

  ps2_voice_allocator #(.NUM_VOICES(NV), .HP_W(HW)) dut (
    .CLOCK_50          (clk),
    .reset             (rst),
    .received_data     (rd),
    .received_data_en  (rd_en),
    .voice_gate        (gate),
    .voice_note        (vnote),
    .voice_half_period (vhp),
    .octave            (oct),
    .pool_full         (full)
  );

  always #10 clk = ~clk;

  function automatic logic [2:0] note_of(input int v);
    return vnote[3*v +: 3];
  endfunction

  function automatic logic [HW-1:0] hp_of(input int v);
    return vhp[HW*v +: HW];
  endfunction

  // One strobe per call; consecutive calls give back-to-back strobes
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rd    = b;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rd = 8'h00; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nvec++; if (gate !== 4'b0000) begin nerr++;
      $display("FAIL rst_gate got %b want 0000", gate); end
    nvec++; if (vnote !== '0) begin nerr++;
      $display("FAIL rst_note got %h want 0", vnote); end
    nvec++; if (vhp !== '0) begin nerr++;
      $display("FAIL rst_hp got %h want 0", vhp); end
    nvec++; if (oct !== 3'd0) begin nerr++;
      $display("FAIL rst_oct got %0d want 0", oct); end
    nvec++; if (full !== 1'b0) begin nerr++;
      $display("FAIL rst_full got %b want 0", full); end
  endtask

  task automatic test_make_break;
    send(8'h16);
    nvec++; if (gate !== 4'b0001) begin nerr++;
      $display("FAIL mk_gate got %b want 0001", gate); end
    nvec++; if (note_of(0) !== 3'd0) begin nerr++;
      $display("FAIL mk_note got %0d want 0", note_of(0)); end
    nvec++; if (hp_of(0) !== 20'd56818) begin nerr++;
      $display("FAIL mk_hp got %0d want 56818", hp_of(0)); end
    send(8'hF0);
    nvec++; if (gate !== 4'b0001) begin nerr++;
      $display("FAIL pfx_gate got %b want 0001", gate); end
    send(8'h16);
    nvec++; if (gate !== 4'b0000) begin nerr++;
      $display("FAIL brk_gate got %b want 0000", gate); end
    nvec++; if (hp_of(0) !== 20'd56818) begin nerr++;
      $display("FAIL brk_hold got %0d want 56818", hp_of(0)); end
    send(8'hF0); send(8'h1E);
    nvec++; if (gate !== 4'b0000) begin nerr++;
      $display("FAIL brk_unheld got %b want 0000", gate); end
  endtask

  task automatic test_octave;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h75);
    nvec++; if ($signed(oct) !== 3'sd2) begin nerr++;
      $display("FAIL oct_up2 got %0d want 2", $signed(oct)); end
    send(8'h3D);
    nvec++; if (gate !== 4'b0001 || note_of(0) !== 3'd6) begin nerr++;
      $display("FAIL oct_mk got %b/%0d want 0001/6", gate, note_of(0)); end
    nvec++; if (hp_of(0) !== 20'd7972) begin nerr++;
      $display("FAIL oct_hp got %0d want 7972", hp_of(0)); end
    for (int i = 0; i < 4; i++) begin send(8'hE0); send(8'h75); end
    nvec++; if ($signed(oct) !== 3'sd3) begin nerr++;
      $display("FAIL oct_sat_hi got %0d want 3", $signed(oct)); end
    nvec++; if (hp_of(0) !== 20'd7972) begin nerr++;
      $display("FAIL oct_noretune got %0d want 7972", hp_of(0)); end
    send(8'hF0); send(8'h3D);
    for (int i = 0; i < 7; i++) begin send(8'hE0); send(8'h72); end
    nvec++; if ($signed(oct) !== -3'sd3) begin nerr++;
      $display("FAIL oct_sat_lo got %0d want -3", $signed(oct)); end
    send(8'h16);
    nvec++; if (hp_of(0) !== 20'd454544) begin nerr++;
      $display("FAIL oct_neg_hp got %0d want 454544", hp_of(0)); end
    send(8'h76);
    for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); end
    nvec++; if (oct !== 3'd0 || gate !== 4'b0000) begin nerr++;
      $display("FAIL oct_back got %0d/%b want 0/0000", $signed(oct), gate); end
  endtask

  task automatic test_ext_break;
    send(8'hE0); send(8'hF0); send(8'h75);
    nvec++; if (oct !== 3'd0) begin nerr++;
      $display("FAIL ext_brk got %0d want 0", $signed(oct)); end
    send(8'h75);
    nvec++; if (oct !== 3'd0) begin nerr++;
      $display("FAIL idle_75 got %0d want 0", $signed(oct)); end
    send(8'h16);
    nvec++; if (gate !== 4'b0001) begin nerr++;
      $display("FAIL ext_idle got %b want 0001", gate); end
    send(8'h76);
  endtask

  task automatic test_fill;
    send(8'h16); send(8'h1E); send(8'h26);
    nvec++; if (full !== 1'b0 || gate !== 4'b0111) begin nerr++;
      $display("FAIL fill3 got %b/%b want 0111/0", gate, full); end
    send(8'h25);
    nvec++; if (gate !== 4'b1111 || full !== 1'b1) begin nerr++;
      $display("FAIL fill_gate got %b/%b want 1111/1", gate, full); end
    nvec++; if (vnote !== 12'b011_010_001_000) begin nerr++;
      $display("FAIL fill_notes got %h want 688", vnote); end
    nvec++; if (hp_of(3) !== 20'd42589) begin nerr++;
      $display("FAIL fill_hp3 got %0d want 42589", hp_of(3)); end
    send(8'h16);
    nvec++; if (gate !== 4'b1111 || vnote !== 12'h688) begin nerr++;
      $display("FAIL repeat got %b/%h want 1111/688", gate, vnote); end
    nvec++; if (hp_of(0) !== 20'd56818) begin nerr++;
      $display("FAIL repeat_hp got %0d want 56818", hp_of(0)); end
  endtask

  task automatic test_full_pool;
    send(8'h2E);
`ifdef VOICE_STEAL_EN
    nvec++; if (note_of(0) !== 3'd4 || hp_of(0) !== 20'd37936) begin
      nerr++; $display("FAIL steal got %0d/%0d want 4/37936",
                       note_of(0), hp_of(0)); end
`else
    nvec++; if (note_of(0) !== 3'd0 || hp_of(0) !== 20'd56818) begin
      nerr++; $display("FAIL drop got %0d/%0d want 0/56818",
                       note_of(0), hp_of(0)); end
`endif
    nvec++; if (gate !== 4'b1111 || full !== 1'b1) begin nerr++;
      $display("FAIL full_keep got %b/%b want 1111/1", gate, full); end
  endtask

  task automatic test_break_realloc;
    send(8'hF0); send(8'h26);
    nvec++; if (gate !== 4'b1011 || full !== 1'b0) begin nerr++;
      $display("FAIL rel2 got %b/%b want 1011/0", gate, full); end
    send(8'h36);
    nvec++; if (gate !== 4'b1111 || note_of(2) !== 3'd5) begin nerr++;
      $display("FAIL realloc got %b/%0d want 1111/5", gate, note_of(2)); end
    nvec++; if (hp_of(2) !== 20'd35817) begin nerr++;
      $display("FAIL realloc_hp got %0d want 35817", hp_of(2)); end
    send(8'h76);
    nvec++; if (gate !== 4'b0000 || full !== 1'b0) begin nerr++;
      $display("FAIL esc got %b/%b want 0000/0", gate, full); end
    nvec++; if (note_of(2) !== 3'd5) begin nerr++;
      $display("FAIL esc_hold got %0d want 5", note_of(2)); end
  endtask

  task automatic test_reset_mid_prefix;
    send(8'hE0); send(8'h75); send(8'h1E); send(8'hF0);
    @(negedge clk);
    rst = 1'b1; rd = 8'h1E; rd_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    nvec++; if (gate !== '0 || vnote !== '0 || vhp !== '0) begin nerr++;
      $display("FAIL mid_rst got %b/%h/%h want 0", gate, vnote, vhp); end
    nvec++; if (oct !== 3'd0 || full !== 1'b0) begin nerr++;
      $display("FAIL mid_rst_oct got %0d/%b want 0/0", oct, full); end
    send(8'h16);
    nvec++; if (gate !== 4'b0001 || hp_of(0) !== 20'd56818) begin nerr++;
      $display("FAIL post_rst got %b/%0d want 0001/56818",
               gate, hp_of(0)); end
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_octave;
    test_ext_break;
    test_fill;
    test_full_pool;
    test_break_realloc;
    test_reset_mid_prefix;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
